kmul_arbiter: RTL and testbench

Shares one two-way Karatsuba GF(2)[x] multiplier core between two requesters. The core has no start or done signals: each multiplication is started by pulsing the core's reset, and the result is valid a fixed number of cycles later. This block arbitrates between the requesters, latches the operands, and pulses the core reset. It then counts the core latency, captures the product and returns it with the requester ID over a valid/ready handshake. It sits between the crypto-op sequencers and the multiplier instance.

---
 rtl/kmul_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_kmul_arbiter.sv | 575 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmul_arbiter.sv
// kmul_arbiter: shares one reset-started Karatsuba GF(2)[x] multiplier
// between two requesters. Optional macro KMUL_ARB_RR_EN selects round-robin.
module kmul_arbiter #(
    parameter int WIDTH   = 571,
    parameter int LATENCY = 290
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_c,
    output logic                 mul_rst,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_c,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_id;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_c;
    logic [15:0]          r_op_count;

    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_req_hs;
    logic                 w_rsp_hs;
    logic                 w_cnt_zero;
    logic                 w_capture;

`ifdef KMUL_ARB_RR_EN
    logic                 r_last;

    // Tie goes to the requester that was not served last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt0 = r_last;
            w_gnt1 = !r_last;
        end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
        end
    end

    // Pointer moves only when a request is actually accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_req_hs) begin
            r_last <= w_gnt1;
        end
    end
`else
    // Fixed priority: requester 0 always wins a tie.
    always_comb begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid && !req0_valid;
    end
`endif

    assign w_cnt_zero = (r_cnt == '0);
    assign w_req_hs   = req0_ready || req1_ready;
    assign w_rsp_hs   = rsp_valid && rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs; readies are gated during reset.
    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        w_capture  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req0_ready = !rst && w_gnt0;
                req1_ready = !rst && w_gnt1;
                if (w_gnt0 || w_gnt1) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                if (w_cnt_zero) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = !rst;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand and owner latch on the request handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_id <= 1'b0;
        end else if (w_req_hs) begin
            r_a  <= w_gnt1 ? req1_a : req0_a;
            r_b  <= w_gnt1 ? req1_b : req0_b;
            r_id <= w_gnt1;
        end
    end

    // Latency counter: loaded while the core is held in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_cnt <= CNT_INIT;
        end else if (r_state == S_RUN && !w_cnt_zero) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Product capture on the last RUN cycle, held through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c <= '0;
        end else if (w_capture) begin
            r_c <= mul_c;
        end
    end

    // Completed-operation counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_rsp_hs) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign mul_rst  = rst || (r_state == S_LOAD);
    assign mul_a    = r_a;
    assign mul_b    = r_b;
    assign rsp_id   = r_id;
    assign rsp_c    = r_c;
    assign busy     = (r_state != S_IDLE);
    assign op_count = r_op_count;

endmodule

// File: tb/tb_kmul_arbiter.sv
// tb_kmul_arbiter: scenario tasks against a behavioural carry-less
// product model and a fixed-latency core model.
module tb_kmul_arbiter;

    localparam int W   = 571;
    localparam int LAT = 290;
    localparam int NW  = (W + 31) / 32;
    localparam int TMO = LAT + 60;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic             req0_ready;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [2*W-1:0]   rsp_c;
    logic             mul_rst;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_c;
    logic             busy;
    logic [15:0]      op_count;

    int               cyc = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    logic [15:0]      m_ops;
    logic             m_last;
    int               core_k = 0;
    logic [2*W-1:0]   w_prod;

    kmul_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_c(rsp_c),
        .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b),
        .mul_c(mul_c), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] clmul(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] r;
        logic [2*W-1:0] x;
        r = '0;
        x = {{W{1'b0}}, a};
        for (int i = 0; i < W; i++) begin
            if (b[i]) r = r ^ (x << i);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [NW*32-1:0] t;
        for (int i = 0; i < NW; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    // Model arbitration: tie goes per configured policy.
    function automatic logic exp_grant(input logic v0, input logic v1,
                                       input logic last);
        if (v0 && v1) begin
`ifdef KMUL_ARB_RR_EN
            return !last;
`else
            return last & 1'b0;
`endif
        end
        return v1 && !v0;
    endfunction

    // Core model: product shows up LAT-1 cycles after reset release.
    always @(posedge clk) begin
        if (mul_rst) core_k <= 0;
        else if (core_k < LAT) core_k <= core_k + 1;
    end
    assign w_prod = clmul(mul_a, mul_b);
    assign mul_c  = (!mul_rst && core_k >= LAT - 1) ? w_prod : '0;

    task automatic issue(input logic id, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int t_hs,
                         output logic rst_ld, output logic rst_run,
                         output logic [W-1:0] a_ld, output bit ok);
        ok = 0;
        t_hs = -1;
        rst_ld = 1'bx;
        rst_run = 1'bx;
        a_ld = 'x;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        for (int i = 0; i < TMO; i++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1;
                t_hs = cyc;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
            m_last = id;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (ok) begin
            @(negedge clk);
            rst_ld = mul_rst;
            a_ld = mul_a;
            @(negedge clk);
            rst_run = mul_rst;
        end
    endtask

    task automatic wait_rsp(output int t_rsp, output logic id,
                            output logic [2*W-1:0] c, output bit ok);
        ok = 0;
        t_rsp = -1;
        id = 1'bx;
        c = 'x;
        for (int i = 0; i < TMO; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1;
                t_rsp = cyc;
                id = rsp_id;
                c = rsp_c;
                break;
            end
            @(negedge clk);
        end
        if (ok && rsp_ready) m_ops = m_ops + 16'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_ready got %b want 00", {req0_ready, req1_ready});
        end
        n_cmp++;
        if ({rsp_valid, rsp_id, busy, mul_rst} !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_ctl got %b want 0001",
                     {rsp_valid, rsp_id, busy, mul_rst});
        end
        n_cmp++;
        if (rsp_c !== '0 || mul_a !== '0 || mul_b !== '0 || op_count !== 16'd0) begin
            n_err++;
            $display("FAIL rst_data got c_lo=%h a_lo=%h cnt=%h want zeros",
                     rsp_c[63:0], mul_a[63:0], op_count);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        m_ops = 16'd0;
        m_last = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL post_rst got %b want 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_single();
        int th, tr;
        logic rl, rr, id;
        logic [W-1:0] one, al;
        logic [2*W-1:0] c;
        bit ok1, ok2;
        one = '0;
        one[0] = 1'b1;
        issue(1'b0, one, one, th, rl, rr, al, ok1);
        wait_rsp(tr, id, c, ok2);
        n_cmp++;
        if (!(ok1 && ok2)) begin
            n_err++;
            $display("FAIL single_timeout got hs=%0d rsp=%0d want 1 1", ok1, ok2);
        end
        n_cmp++;
        if (tr - th !== LAT + 2) begin
            n_err++;
            $display("FAIL single_lat got %0d want %0d", tr - th, LAT + 2);
        end
        n_cmp++;
        if (c !== {{(2*W-1){1'b0}}, 1'b1} || id !== 1'b0) begin
            n_err++;
            $display("FAIL single_rsp got id=%b c_lo=%h want id=0 c=1",
                     id, c[63:0]);
        end
        n_cmp++;
        if (rl !== 1'b1 || rr !== 1'b0 || al !== one) begin
            n_err++;
            $display("FAIL single_load got rst=%b%b a_lo=%h want 10 a=1",
                     rl, rr, al[63:0]);
        end
        @(negedge clk);
        n_cmp++;
        if (op_count !== 16'd1) begin
            n_err++;
            $display("FAIL single_cnt got %0d want 1", op_count);
        end
    endtask

    task automatic test_shift();
        int th, tr;
        logic rl, rr, id;
        logic [W-1:0] a, b, al;
        logic [2*W-1:0] c, e;
        bit ok1, ok2;
        a = '0; a[W-1] = 1'b1;
        b = '0; b[1] = 1'b1;
        e = '0; e[W] = 1'b1;
        issue(1'b1, a, b, th, rl, rr, al, ok1);
        wait_rsp(tr, id, c, ok2);
        n_cmp++;
        if (!(ok1 && ok2) || c !== e || id !== 1'b1) begin
            n_err++;
            $display("FAIL shift_msb got id=%b c_hi=%h c_lo=%h want id=1 c_hi=%h c_lo=%h",
                     id, c[2*W-1 -: 64], c[63:0], e[2*W-1 -: 64], e[63:0]);
        end
        a = '1;
        b = '0; b[0] = 1'b1;
        e = {{W{1'b0}}, a};
        issue(1'b0, a, b, th, rl, rr, al, ok1);
        wait_rsp(tr, id, c, ok2);
        n_cmp++;
        if (!(ok1 && ok2) || c !== e || id !== 1'b0) begin
            n_err++;
            $display("FAIL shift_ones got id=%b c_hi=%h c_lo=%h want id=0 c_hi=%h c_lo=%h",
                     id, c[2*W-1 -: 64], c[63:0], e[2*W-1 -: 64], e[63:0]);
        end
        @(negedge clk);
        n_cmp++;
        if (op_count !== m_ops) begin
            n_err++;
            $display("FAIL shift_cnt got %0d want %0d", op_count, m_ops);
        end
    endtask

    task automatic test_back_to_back();
        int th, t_rv, t_rdy, tr;
        logic rl, rr, id1, id2;
        logic [W-1:0] a1, b1, a2, b2, al;
        logic [2*W-1:0] c1, c2;
        bit ok1, ok2;
        a1 = rnd_op(); b1 = rnd_op();
        a2 = rnd_op(); b2 = rnd_op();
        t_rv = -1;
        t_rdy = -1;
        id1 = 1'bx;
        c1 = 'x;
        issue(1'b0, a1, b1, th, rl, rr, al, ok1);
        req0_valid = 1'b1;
        req0_a = a2;
        req0_b = b2;
        for (int i = 0; i < TMO; i++) begin
            #1;
            if (rsp_valid === 1'b1 && t_rv < 0) begin
                t_rv = cyc; id1 = rsp_id; c1 = rsp_c;
            end
            if (req0_ready === 1'b1) begin
                t_rdy = cyc;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        if (t_rdy >= 0) m_last = 1'b0;
        if (t_rv >= 0) m_ops = m_ops + 16'd1;
        @(negedge clk);
        wait_rsp(tr, id2, c2, ok2);
        n_cmp++;
        if (t_rv - th !== LAT + 2 || t_rdy - th !== LAT + 3) begin
            n_err++;
            $display("FAIL b2b_timing got rv=%0d rdy=%0d want %0d %0d",
                     t_rv - th, t_rdy - th, LAT + 2, LAT + 3);
        end
        n_cmp++;
        if (!ok1 || c1 !== clmul(a1, b1) || id1 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first got id=%b c_lo=%h want id=0 c_lo=%h",
                     id1, c1[63:0], clmul(a1, b1) & 64'hFFFF_FFFF_FFFF_FFFF);
        end
        n_cmp++;
        if (!ok2 || c2 !== clmul(a2, b2) || tr - t_rdy !== LAT + 2) begin
            n_err++;
            $display("FAIL b2b_second got lat=%0d c_lo=%h want lat=%0d c_lo=%h",
                     tr - t_rdy, c2[63:0], LAT + 2,
                     clmul(a2, b2) & 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] a0, b0, a1, b1;
        logic [2*W-1:0] c, e;
        logic g, eg, id;
        int tr;
        bit ok, got;
        a0 = rnd_op(); b0 = rnd_op();
        a1 = rnd_op(); b1 = rnd_op();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = a0; req0_b = b0;
        req1_valid = 1'b1; req1_a = a1; req1_b = b1;
        for (int k = 0; k < 6; k++) begin
            got = 0;
            g = 1'bx;
            eg = exp_grant(req0_valid, req1_valid, m_last);
            for (int i = 0; i < TMO; i++) begin
                #1;
                if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                    got = 1;
                    break;
                end
                @(negedge clk);
            end
            n_cmp++;
            if (!got || (req0_ready & req1_ready) !== 1'b0 || req1_ready !== eg) begin
                n_err++;
                $display("FAIL cont_grant[%0d] got r0=%b r1=%b want grant %b",
                         k, req0_ready, req1_ready, eg);
            end
            g = req1_ready;
            e = g ? clmul(a1, b1) : clmul(a0, b0);
            @(posedge clk);
            #1;
            m_last = g;
            if (g) begin
                a1 = rnd_op(); b1 = rnd_op();
                req1_a = a1; req1_b = b1;
            end else begin
                a0 = rnd_op(); b0 = rnd_op();
                req0_a = a0; req0_b = b0;
            end
            if (k == 5) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
            wait_rsp(tr, id, c, ok);
            n_cmp++;
            if (!ok || id !== g || c !== e) begin
                n_err++;
                $display("FAIL cont_rsp[%0d] got id=%b c_lo=%h want id=%b c_lo=%h",
                         k, id, c[63:0], g, e[63:0]);
            end
            if (k == 3) req0_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (op_count !== m_ops) begin
            n_err++;
            $display("FAIL cont_cnt got %0d want %0d", op_count, m_ops);
        end
    endtask

    task automatic test_backpressure();
        int th, tr;
        logic rl, rr, id;
        logic [W-1:0] a, b, al;
        logic [2*W-1:0] c;
        bit ok1, ok2, bad_hold, bad_rdy, bad_pulse;
        a = rnd_op(); b = rnd_op();
        bad_hold = 0; bad_rdy = 0; bad_pulse = 0;
        rsp_ready = 1'b0;
        issue(1'b1, a, b, th, rl, rr, al, ok1);
        wait_rsp(tr, id, c, ok2);
        n_cmp++;
        if (!(ok1 && ok2) || c !== clmul(a, b) || id !== 1'b1) begin
            n_err++;
            $display("FAIL bp_rsp got id=%b c_lo=%h want id=1 c_lo=%h",
                     id, c[63:0], clmul(a, b) & 64'hFFFF_FFFF_FFFF_FFFF);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_c !== c || rsp_id !== id) bad_hold = 1;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bad_rdy = 1;
            if (mul_rst !== 1'b0) bad_pulse = 1;
        end
        n_cmp++;
        if (bad_hold) begin
            n_err++;
            $display("FAIL bp_hold got unstable rsp want stable");
        end
        n_cmp++;
        if (bad_rdy) begin
            n_err++;
            $display("FAIL bp_ready got ready high want 0");
        end
        n_cmp++;
        if (bad_pulse) begin
            n_err++;
            $display("FAIL bp_mulrst got pulse want none");
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        m_ops = m_ops + 16'd1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== m_ops) begin
            n_err++;
            $display("FAIL bp_release got v=%b busy=%b cnt=%0d want 0 0 %0d",
                     rsp_valid, busy, op_count, m_ops);
        end
    endtask

    task automatic test_random();
        int th, tr, dly;
        logic rl, rr, id, rid;
        logic [W-1:0] a, b, al;
        logic [2*W-1:0] c;
        bit ok1, ok2;
        for (int k = 0; k < 8; k++) begin
            rid = 1'($urandom_range(0, 1));
            a = rnd_op();
            b = rnd_op();
            if (k == 0) b = '0;
            dly = $urandom_range(0, 5);
            rsp_ready = (dly == 0);
            issue(rid, a, b, th, rl, rr, al, ok1);
            wait_rsp(tr, id, c, ok2);
            n_cmp++;
            if (!(ok1 && ok2) || tr - th !== LAT + 2 || id !== rid || c !== clmul(a, b)) begin
                n_err++;
                $display("FAIL rand[%0d] got lat=%0d id=%b c_lo=%h want lat=%0d id=%b c_lo=%h",
                         k, tr - th, id, c[63:0], LAT + 2, rid,
                         clmul(a, b) & 64'hFFFF_FFFF_FFFF_FFFF);
            end
            if (dly != 0) begin
                repeat (dly) @(negedge clk);
                rsp_ready = 1'b1;
                m_ops = m_ops + 16'd1;
            end
            @(negedge clk);
            n_cmp++;
            if (op_count !== m_ops) begin
                n_err++;
                $display("FAIL rand_cnt[%0d] got %0d want %0d", k, op_count, m_ops);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int th, tr;
        logic rl, rr, id;
        logic [W-1:0] a, b, al;
        logic [2*W-1:0] c;
        bit ok1, ok2, seen;
        a = rnd_op(); b = rnd_op();
        issue(1'b0, a, b, th, rl, rr, al, ok1);
        for (int i = 0; i < 200 && cyc < th + 100; i++) @(negedge clk);
        rst = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (!ok1 || busy !== 1'b0 || rsp_valid !== 1'b0 || mul_rst !== 1'b1
            || req1_ready !== 1'b0 || op_count !== 16'd0 || mul_a !== '0) begin
            n_err++;
            $display("FAIL mid_rst got busy=%b v=%b mrst=%b rdy=%b cnt=%0d want 0 0 1 0 0",
                     busy, rsp_valid, mul_rst, req1_ready, op_count);
        end
        rst = 1'b0;
        req1_valid = 1'b0;
        m_ops = 16'd0;
        m_last = 1'b1;
        seen = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL mid_rst_ghost got rsp_valid=1 want 0");
        end
        a = rnd_op(); b = rnd_op();
        issue(1'b1, a, b, th, rl, rr, al, ok1);
        wait_rsp(tr, id, c, ok2);
        n_cmp++;
        if (!(ok1 && ok2) || id !== 1'b1 || c !== clmul(a, b) || tr - th !== LAT + 2) begin
            n_err++;
            $display("FAIL mid_rst_after got id=%b lat=%0d c_lo=%h want id=1 lat=%0d c_lo=%h",
                     id, tr - th, c[63:0], LAT + 2,
                     clmul(a, b) & 64'hFFFF_FFFF_FFFF_FFFF);
        end
        @(negedge clk);
        n_cmp++;
        if (op_count !== m_ops) begin
            n_err++;
            $display("FAIL mid_rst_cnt got %0d want %0d", op_count, m_ops);
        end
    endtask

    task automatic test_wrap();
        int th, tr;
        logic rl, rr, id;
        logic [W-1:0] a, b, al;
        logic [2*W-1:0] c;
        bit ok1, ok2;
        @(negedge clk);
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        m_ops = 16'hFFFF;
        a = rnd_op(); b = rnd_op();
        issue(1'b0, a, b, th, rl, rr, al, ok1);
        wait_rsp(tr, id, c, ok2);
        @(negedge clk);
        n_cmp++;
        if (!(ok1 && ok2) || op_count !== m_ops || c !== clmul(a, b)) begin
            n_err++;
            $display("FAIL wrap got cnt=%0d want %0d", op_count, m_ops);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0;
        req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        m_ops = 16'd0;
        m_last = 1'b1;
        test_reset();
        test_single();
        test_shift();
        test_back_to_back();
        test_contention();
        test_backpressure();
        test_random();
        test_reset_mid_run();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
